// File: rtl/demux_lane_pkg.sv
// Shared lane geometry and helpers for the 1-to-32 x 2-bit symbol deserializer.
// Defaults describe a 32-lane, 2-bit-per-lane packed frame (64 bits).
package demux_lane_pkg;

  localparam int LANES_DEF   = 32;
  localparam int LANE_W_DEF  = 2;
  localparam int SEL_W_DEF   = $clog2(LANES_DEF);
  localparam int FRAME_W_DEF = LANES_DEF * LANE_W_DEF;

  typedef logic [LANE_W_DEF-1:0]  lane_t;
  typedef logic [SEL_W_DEF-1:0]   sel_t;
  typedef logic [FRAME_W_DEF-1:0] frame_t;

  // Return the frame with lane idx replaced by sym (lane k at [k*LANE_W +: LANE_W]).
  function automatic frame_t lane_insert(input frame_t frame, input sel_t idx, input lane_t sym);
    frame_t result;
    result = frame;
    result[int'(idx)*LANE_W_DEF +: LANE_W_DEF] = sym;
    return result;
  endfunction

endpackage

// File: rtl/demux_frame_reg.sv
// Output holding register for completed frames with a valid/ready handshake.
// A load in the same cycle as a drain keeps out_valid high and replaces the
// frame, so back-to-back frames leave no bubble on the output.
module demux_frame_reg
  import demux_lane_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_frame,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] data_out
);

  logic               valid_reg;
  logic [FRAME_W-1:0] data_reg;

  // Load a new frame (wins over a drain); otherwise a taken frame clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_frame;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign data_out  = data_reg;

endmodule

// File: rtl/demux_1to32_2b_seq.sv
// Sequential 1-to-32 demultiplexer for 2-bit symbols: assembles one lane per
// accepted symbol and hands each finished 64-bit frame to a holding register.
// Optional feature macro: DEMUX_SEL_PORT_EN adds in_sel for random-order lane
// writes, with completion tracked by a per-lane written mask.
module demux_1to32_2b_seq
  import demux_lane_pkg::*;
#(
  parameter  int LANES   = LANES_DEF,
  parameter  int LANE_W  = LANE_W_DEF,
  localparam int SEL_W   = $clog2(LANES),
  localparam int FRAME_W = LANES * LANE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANE_W-1:0]  in_data,
`ifdef DEMUX_SEL_PORT_EN
  input  logic [SEL_W-1:0]   in_sel,
`endif
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] data_out,
  output logic [SEL_W-1:0]   wr_lane
);

  logic               accept;
  logic               completes;
  logic               load;
  logic [SEL_W-1:0]   wr_idx;
  logic [FRAME_W-1:0] load_frame;

  // A symbol presented with flush is dropped; flush only restarts assembly.
  assign accept = in_valid && in_ready && !flush;
  assign load   = accept && completes;

  // Stall only when this symbol would finish a frame that has nowhere to go.
  assign in_ready = !(completes && out_valid && !out_ready);

`ifdef DEMUX_SEL_PORT_EN
  logic [LANES-1:0] mask_reg;
  logic [LANES-1:0] mask_set;
  logic [LANES-1:0] mask_next;
  logic [SEL_W-1:0] wr_lane_reg;
  logic [SEL_W-1:0] lane_next;

  assign wr_idx    = in_sel;
  assign mask_set  = mask_reg | (LANES'(1) << in_sel);
  // Rewriting a lane already in the mask leaves it unchanged, so no early completion.
  assign completes = &mask_set;

  // Next written-lane mask: cleared by flush or by the completing write.
  always_comb begin
    mask_next = mask_reg;
    if (flush) begin
      mask_next = '0;
    end else if (accept) begin
      mask_next = completes ? '0 : mask_set;
    end
  end

  // Lowest unwritten lane of the next mask, reported as wr_lane.
  always_comb begin
    lane_next = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!mask_next[i]) begin
        lane_next = SEL_W'(i);
      end
    end
  end

  // Mask and its lowest-clear index are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg    <= '0;
      wr_lane_reg <= '0;
    end else begin
      mask_reg    <= mask_next;
      wr_lane_reg <= lane_next;
    end
  end

  assign wr_lane = wr_lane_reg;
`else
  logic [SEL_W-1:0] wr_ptr_reg;

  assign wr_idx    = wr_ptr_reg;
  assign completes = (wr_ptr_reg == SEL_W'(LANES - 1));

  // Sequential write pointer; wraps naturally since LANES is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
    end else if (accept) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
    end
  end

  assign wr_lane = wr_ptr_reg;
`endif

  // Assembly register, one lane register per slot. The completing symbol is
  // bypassed straight into load_frame so the frame lands one cycle later.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_reg;
      logic              lane_hit;

      assign lane_hit = (wr_idx == SEL_W'(gi));

      // Capture the accepted symbol for this lane; never cleared between frames.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= '0;
        end else if (accept && lane_hit) begin
          lane_reg <= in_data;
        end
      end

      assign load_frame[gi*LANE_W +: LANE_W] = lane_hit ? in_data : lane_reg;
    end
  endgenerate

  demux_frame_reg #(
    .FRAME_W (FRAME_W)
  ) u_frame_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_frame (load_frame),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .data_out   (data_out)
  );

endmodule

// File: tb/tb_demux_1to32_2b_seq.sv
// Table-driven bench for demux_1to32_2b_seq. Each record holds the inputs for
// one cycle and the outputs expected while those inputs are presented.
module tb_demux_1to32_2b_seq;

  localparam logic [63:0] F_E4 = 64'hE4E4_E4E4_E4E4_E4E4;
  localparam logic [63:0] F_FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] F_AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] F_55 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] F_00 = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_data = 2'b00;
  logic [4:0]  in_sel = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] data_out;
  logic [4:0]  wr_lane;

  typedef struct {
    string       tag;
    logic        rst_n;
    logic        v;
    logic [1:0]  d;
    logic [4:0]  sel;
    logic        fl;
    logic        ordy;
    logic        exp_ird;
    logic        exp_ov;
    logic [63:0] exp_do;
    logic [4:0]  exp_wl;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  demux_1to32_2b_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef DEMUX_SEL_PORT_EN
    .in_sel    (in_sel),
`endif
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .wr_lane   (wr_lane)
  );

  function automatic void add(input string tag, input logic r, input logic v,
                              input logic [1:0] d, input logic [4:0] sel,
                              input logic fl, input logic ordy, input logic ird,
                              input logic ov, input logic [63:0] dout,
                              input logic [4:0] wl);
    vec_t x;
    x.tag = tag; x.rst_n = r; x.v = v; x.d = d; x.sel = sel; x.fl = fl;
    x.ordy = ordy; x.exp_ird = ird; x.exp_ov = ov; x.exp_do = dout; x.exp_wl = wl;
    vecs.push_back(x);
  endfunction

  // Reset-state check while rst_n is held low from time 0.
  initial begin
    #2;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== F_00 || wr_lane !== 5'd0) begin
      miscompares++;
      $display("FAIL reset state: in_ready=%b out_valid=%b data_out=%h wr_lane=%0d",
               in_ready, out_valid, data_out, wr_lane);
    end else begin
      $display("reset state ok: in_ready=%b out_valid=%b data_out=%h wr_lane=%0d",
               in_ready, out_valid, data_out, wr_lane);
    end
  end

  // Expired-wait check: the vector run must finish within the time bound.
  initial begin
    #200000;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: only %0d of %0d vectors applied", applied, vecs.size());
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
    end
  end

  initial begin
    // Reset state, then release.
    add("reset", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_00, 5'd0);
    add("reset", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_00, 5'd0);

    // Stream i%4 with out_ready high.
    for (int i = 0; i < 32; i++)
      add("stream", 1'b1, 1'b1, 2'(i % 4), 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'(i));
    add("stream_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_E4, 5'd0);
    add("stream_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_E4, 5'd0);

    // Hold: out_ready low, 63 symbols, stall at lane 31, one-cycle drain, 64th symbol.
    for (int i = 0; i < 32; i++)
      add("hold_a", 1'b1, 1'b1, 2'd3, 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, F_E4, 5'(i));
    for (int i = 0; i < 31; i++)
      add("hold_b", 1'b1, 1'b1, 2'd2, 5'(i), 1'b0, 1'b0, 1'b1, 1'b1, F_FF, 5'(i));
    for (int i = 0; i < 2; i++)
      add("hold_stall", 1'b1, 1'b1, 2'd2, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, F_FF, 5'd31);
    add("hold_drain", 1'b1, 1'b0, 2'd0, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, F_FF, 5'd31);
    add("hold_last", 1'b1, 1'b1, 2'd2, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, F_FF, 5'd31);
    add("hold_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_AA, 5'd0);
    add("hold_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_AA, 5'd0);

    // Back-to-back frames: all 3 then all 0.
    for (int i = 0; i < 64; i++)
      add("b2b", 1'b1, 1'b1, (i < 32) ? 2'd3 : 2'd0, 5'(i % 32), 1'b0, 1'b1, 1'b1,
          (i == 32), (i < 32) ? F_AA : F_FF, 5'(i % 32));
    add("b2b_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_00, 5'd0);
    add("b2b_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'd0);

    // Flush after 10 symbols; the symbol presented with flush is dropped.
    for (int i = 0; i < 10; i++)
      add("flush_pre", 1'b1, 1'b1, 2'd1, 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'(i));
    add("flush", 1'b1, 1'b1, 2'd3, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, F_00, 5'd10);
    for (int i = 0; i < 32; i++)
      add("flush_post", 1'b1, 1'b1, 2'd2, 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'(i));
    add("flush_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_AA, 5'd0);
    add("flush_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_AA, 5'd0);

    // Drain and load in the same cycle: out_valid stays high, frame replaced.
    for (int i = 0; i < 32; i++)
      add("dl_a", 1'b1, 1'b1, 2'd1, 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, F_AA, 5'(i));
    for (int i = 0; i < 31; i++)
      add("dl_b", 1'b1, 1'b1, 2'd3, 5'(i), 1'b0, 1'b0, 1'b1, 1'b1, F_55, 5'(i));
    add("dl_both", 1'b1, 1'b1, 2'd3, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, F_55, 5'd31);
    add("dl_held", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, F_FF, 5'd0);
    add("dl_take", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_FF, 5'd0);
    add("dl_idle", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FF, 5'd0);

    // Asynchronous reset at lane 17 while a frame is held.
    for (int i = 0; i < 32; i++)
      add("ar_a", 1'b1, 1'b1, 2'd1, 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, F_FF, 5'(i));
    for (int i = 0; i < 17; i++)
      add("ar_b", 1'b1, 1'b1, 2'd2, 5'(i), 1'b0, 1'b0, 1'b1, 1'b1, F_55, 5'(i));
    add("ar_assert", 1'b0, 1'b0, 2'd0, 5'd17, 1'b0, 1'b0, 1'b1, 1'b0, F_00, 5'd0);
    add("ar_release", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_00, 5'd0);
    for (int i = 0; i < 32; i++)
      add("ar_stream", 1'b1, 1'b1, 2'(i % 4), 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'(i));
    add("ar_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_E4, 5'd0);
    add("ar_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_E4, 5'd0);

`ifdef DEMUX_SEL_PORT_EN
    // Random-order lanes 31..0 with an early write to lane 5 that is later rewritten.
    add("sel_rst", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'd0);
    add("sel_rst", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'd0);
    add("sel_pre5", 1'b1, 1'b1, 2'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'd0);
    for (int i = 0; i < 32; i++)
      add("sel_down", 1'b1, 1'b1, 2'((31 - i) % 4), 5'(31 - i), 1'b0, 1'b1, 1'b1, 1'b0, F_00, 5'd0);
    add("sel_out", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, F_E4, 5'd0);
    add("sel_drn", 1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_E4, 5'd0);
`endif

    // Apply each record at the falling edge and check 1 time unit later.
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst_n     = vecs[k].rst_n;
      in_valid  = vecs[k].v;
      in_data   = vecs[k].d;
      in_sel    = vecs[k].sel;
      flush     = vecs[k].fl;
      out_ready = vecs[k].ordy;
      #1;
      applied++;
      if (in_ready !== vecs[k].exp_ird || out_valid !== vecs[k].exp_ov ||
          data_out !== vecs[k].exp_do || wr_lane !== vecs[k].exp_wl) begin
        miscompares++;
        $display("FAIL vec %0d %s: got in_ready=%b out_valid=%b data_out=%h wr_lane=%0d, want in_ready=%b out_valid=%b data_out=%h wr_lane=%0d",
                 k, vecs[k].tag, in_ready, out_valid, data_out, wr_lane,
                 vecs[k].exp_ird, vecs[k].exp_ov, vecs[k].exp_do, vecs[k].exp_wl);
      end else begin
        $display("vec %0d %s ok: v=%b d=%0d fl=%b ordy=%b -> in_ready=%b out_valid=%b data_out=%h wr_lane=%0d",
                 k, vecs[k].tag, vecs[k].v, vecs[k].d, vecs[k].fl, vecs[k].ordy,
                 in_ready, out_valid, data_out, wr_lane);
      end
    end

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
